// File: rtl/cmn_clk_div_gen_if.sv
// cmn_clk_div_gen_if: channel-enable, config handshake and divided-clock outputs of cmn_clk_div_gen
//  ch_en     master->slave  per-channel run enable
//  cfg_vld   master->slave  config write request
//  cfg_ch    master->slave  channel index of config write
//  cfg_div   master->slave  new divide ratio (0 treated as 1)
//  cfg_rdy   slave->master  write accepted when cfg_vld & cfg_rdy
//  cfg_err   slave->master  one-cycle pulse: out-of-range write dropped
//  upd_pend  slave->master  channel holds an accepted ratio not yet applied
//  clk_en    slave->master  one-cycle enable pulse per period
//  clk_div   slave->master  divided square wave
interface cmn_clk_div_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_vld;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_rdy;
    logic              cfg_err;
    logic [NUM_CH-1:0] upd_pend;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] clk_div;
    modport master (
        output ch_en, cfg_vld, cfg_ch, cfg_div,
        input  cfg_rdy, cfg_err, upd_pend, clk_en, clk_div
    );
    modport slave (
        input  ch_en, cfg_vld, cfg_ch, cfg_div,
        output cfg_rdy, cfg_err, upd_pend, clk_en, clk_div
    );
endinterface

// File: rtl/cmn_clk_div_gen.sv
// cmn_clk_div_gen: multi-channel programmable clock-enable / divided-clock generator
//  clk     in     reference clock, rising-edge
//  rst     in     synchronous reset, active-high
//  bus_io  slave  cmn_clk_div_gen_if: ch_en, cfg_vld/cfg_ch/cfg_div in; cfg_rdy, cfg_err, upd_pend, clk_en, clk_div out
module cmn_clk_div_gen #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 8,
    parameter int RST_DIV = 2
) (
    input logic             clk,
    input logic             rst,
    cmn_clk_div_gen_if.slave bus_io
);
    localparam int RST_CUR = (RST_DIV == 0) ? 1 : RST_DIV;
    logic [NUM_CH-1:0]            en_q, pend_q, pend_d, tc, apply, sel, clk_en_w, clk_div_w;
    logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d, cur_q, cur_d, nxt_q, nxt_d;
    logic                         err_q, cfg_oor, cfg_wr;
    logic [DIV_W-1:0]             cfg_div_n;

    assign cfg_oor        = 32'(bus_io.cfg_ch) >= NUM_CH;
    // A channel with a pending ratio refuses further writes until it applies it
    assign bus_io.cfg_rdy = cfg_oor | ~pend_q[bus_io.cfg_ch];
    assign cfg_wr         = bus_io.cfg_vld & bus_io.cfg_rdy & ~cfg_oor;
    assign cfg_div_n      = (bus_io.cfg_div == '0) ? DIV_W'(1) : bus_io.cfg_div;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign tc[i]        = cnt_q[i] == cur_q[i] - DIV_W'(1);
        // Stopped channels take a pending ratio at once; running ones only at the period boundary
        assign apply[i]     = pend_q[i] & (~en_q[i] | tc[i]);
        // Using ch_en here zeroes the count on the same edge en_q drops
        assign cnt_d[i]     = (bus_io.ch_en[i] & en_q[i] & ~tc[i]) ? cnt_q[i] + DIV_W'(1) : '0;
        assign cur_d[i]     = apply[i] ? nxt_q[i] : cur_q[i];
        assign sel[i]       = cfg_wr & (32'(bus_io.cfg_ch) == i);
        assign nxt_d[i]     = sel[i] ? cfg_div_n : nxt_q[i];
        assign pend_d[i]    = sel[i] | (pend_q[i] & ~apply[i]);
        assign clk_en_w[i]  = en_q[i] & tc[i];
        // High for the first ceil(div/2) counts of the period
        assign clk_div_w[i] = en_q[i] & (cnt_q[i] < cur_q[i] - (cur_q[i] >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= '0;
            cnt_q  <= '0;
            cur_q  <= {NUM_CH{DIV_W'(RST_CUR)}};
            nxt_q  <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            en_q   <= bus_io.ch_en;
            cnt_q  <= cnt_d;
            cur_q  <= cur_d;
            nxt_q  <= nxt_d;
            pend_q <= pend_d;
            err_q  <= bus_io.cfg_vld & cfg_oor;
        end
    end

    assign bus_io.cfg_err  = err_q;
    assign bus_io.upd_pend = pend_q;
    assign bus_io.clk_en   = clk_en_w;
    assign bus_io.clk_div  = clk_div_w;
endmodule
